// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter and future RX-side schedulers.
package uart_pkg;

    localparam int BYTE_W = 8;

    // GAP is only reachable when the design is built with UART_ARB_GAP_EN.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the start/busy handshake of the shared transmitter.
// slave = arbiter side, master = requesters and transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [uart_pkg::BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_last;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               tx_start;
    logic [uart_pkg::BYTE_W-1:0]        tx_data;
    logic                               tx_busy;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data
    );

endinterface

// File: rtl/uart_rr_picker.sv
// Rotate-priority encoder: first set request scanning ptr_i, ptr_i+1, ... mod NUM_REQ.
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               found_o
);

    int              sum;
    logic [ID_W-1:0] idx;

    // Scan from the farthest slot back to ptr_i so the closest hit is written last.
    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        sum      = 0;
        idx      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(ptr_i) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = sum[ID_W-1:0];
            if (req_i[idx]) begin
                winner_o = idx;
                found_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking in front of one byte-serial UART transmitter.
// Optional macro UART_ARB_GAP_EN adds a GAP state of GAP_TICKS idle clocks after each byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int GAP_TICKS    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_arbiter_if.slave bus_if,
    output logic [ID_W-1:0] grant_id,
    output logic            locked,
    output logic            lock_abort
);

    localparam logic [15:0] TO_LAST = 16'(LOCK_TIMEOUT - 1);

    arb_state_e          state_q, state_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic                locked_q, locked_d;
    logic                abort_q, abort_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [15:0]         to_cnt_q, to_cnt_d;

    logic [NUM_REQ-1:0]  cand;
    logic [ID_W-1:0]     winner;
    logic                found;
    logic [NUM_REQ-1:0]  ready_c;
    logic                start_c;

`ifdef UART_ARB_GAP_EN
    localparam logic [15:0] GAP_LAST = (GAP_TICKS == 0) ? 16'd0 : 16'(GAP_TICKS - 1);
    logic [15:0]         gap_cnt_q, gap_cnt_d;
`else
    // Without the gap state the spacing parameter has no effect.
    logic                unused_gap_ticks;
    assign unused_gap_ticks = ^GAP_TICKS;
`endif

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // While a packet is open only its owner may compete; the picker then sees a single bit.
    always_comb begin
        cand = bus_if.req_valid;
        if (locked_q) begin
            cand = bus_if.req_valid & (NUM_REQ'(1) << grant_q);
        end
    end

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_i    (cand),
        .ptr_i    (rr_q),
        .winner_o (winner),
        .found_o  (found)
    );

    // Next-state, acceptance, lock and timeout decisions.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        locked_d  = locked_q;
        abort_d   = 1'b0;
        rr_d      = rr_q;
        to_cnt_d  = to_cnt_q;
        ready_c   = '0;
        start_c   = 1'b0;
`ifdef UART_ARB_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found && !bus_if.tx_busy) begin
                    ready_c[winner] = 1'b1;
                    tx_data_d       = bus_if.req_data[BYTE_W*int'(winner) +: BYTE_W];
                    grant_d         = winner;
                    to_cnt_d        = '0;
                    state_d         = START;
                    if (bus_if.req_last[winner]) begin
                        locked_d = 1'b0;
                        rr_d     = next_idx(winner);
                    end else begin
                        locked_d = 1'b1;
                    end
                end else if (locked_q && !bus_if.req_valid[grant_q]) begin
                    // Owner stalled mid-packet: release the lock once the budget runs out.
                    if (to_cnt_q == TO_LAST) begin
                        locked_d = 1'b0;
                        abort_d  = 1'b1;
                        rr_d     = next_idx(grant_q);
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                end
            end
            START: begin
                start_c = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus_if.tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus_if.tx_busy) begin
`ifdef UART_ARB_GAP_EN
                    state_d   = GAP;
                    gap_cnt_d = '0;
`else
                    state_d   = IDLE;
`endif
                end
            end
`ifdef UART_ARB_GAP_EN
            GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers; a reset abandons any partially sent packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            grant_q   <= '0;
            locked_q  <= 1'b0;
            abort_q   <= 1'b0;
            rr_q      <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            locked_q  <= locked_d;
            abort_q   <= abort_d;
            rr_q      <= rr_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

`ifdef UART_ARB_GAP_EN
    // Inter-byte gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    assign bus_if.req_ready = ready_c;
    assign bus_if.tx_start  = start_c;
    assign bus_if.tx_data   = tx_data_q;
    assign grant_id         = grant_q;
    assign locked           = locked_q;
    assign lock_abort       = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_GAP_EN
    localparam int EXTRA = 5;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] grant_id;
    logic       locked;
    logic       lock_abort;

    logic       busy_model;
    logic       busy_hold;
    logic       pend;
    int         busy_cnt;
    int         frame_len;

    int         errors;
    int         checks;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .ID_W         (2),
        .LOCK_TIMEOUT (16),
        .GAP_TICKS    (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_if     (bus),
        .grant_id   (grant_id),
        .locked     (locked),
        .lock_abort (lock_abort)
    );

    assign bus.tx_busy = busy_model | busy_hold;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy rises one clock after the start pulse, lasts frame_len clocks.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_model = 1'b0;
            pend       = 1'b0;
            busy_cnt   = 0;
        end else if (pend) begin
            pend       = 1'b0;
            busy_model = 1'b1;
            busy_cnt   = frame_len;
        end else if (busy_cnt != 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) busy_model = 1'b0;
        end else if (bus.tx_start) begin
            pend = 1'b1;
        end
    end

    typedef struct packed {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        hold;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_data;
        logic [1:0]  exp_grant;
        logic        exp_locked;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    endtask

    // Wait for one transmitter frame; returns with the next tick being the first IDLE cycle.
    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (!bus.tx_busy && n < 50) begin
            tick();
            n++;
        end
        check({name, "_busy_rise"}, 32'(bus.tx_busy), 32'd1);
        n = 0;
        while (bus.tx_busy && n < 300) begin
            tick();
            n++;
        end
        check({name, "_busy_fall"}, 32'(bus.tx_busy), 32'd0);
        repeat (EXTRA) tick();
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        busy_hold = 1'b0;
        drive(4'h0, 4'h0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int t;
        int fall_t;
        logic prev_busy;

        errors    = 0;
        checks    = 0;
        frame_len = 4;
        busy_hold = 1'b0;
        drive(4'h0, 4'h0, 32'h0);

        //            valid  last   data          hold ready  data   grant lock
        vecs[0]  = '{4'h0, 4'hF, 32'h13121110, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0};
        vecs[1]  = '{4'h2, 4'hF, 32'h1312A510, 1'b0, 4'h2, 8'hA5, 2'd1, 1'b0};
        vecs[2]  = '{4'hF, 4'hF, 32'h13121110, 1'b0, 4'h4, 8'h12, 2'd2, 1'b0};
        vecs[3]  = '{4'hF, 4'hF, 32'h13121110, 1'b0, 4'h8, 8'h13, 2'd3, 1'b0};
        vecs[4]  = '{4'hF, 4'hF, 32'h13121110, 1'b0, 4'h1, 8'h10, 2'd0, 1'b0};
        vecs[5]  = '{4'hF, 4'hF, 32'h13121110, 1'b0, 4'h2, 8'h11, 2'd1, 1'b0};
        vecs[6]  = '{4'h1, 4'h0, 32'h13121130, 1'b0, 4'h1, 8'h30, 2'd0, 1'b1};
        vecs[7]  = '{4'h5, 4'h4, 32'h13121131, 1'b0, 4'h1, 8'h31, 2'd0, 1'b1};
        vecs[8]  = '{4'h5, 4'h5, 32'h13121132, 1'b0, 4'h1, 8'h32, 2'd0, 1'b0};
        vecs[9]  = '{4'h5, 4'h5, 32'h13121133, 1'b0, 4'h4, 8'h12, 2'd2, 1'b0};
        vecs[10] = '{4'hF, 4'hF, 32'h13121110, 1'b1, 4'h0, 8'h12, 2'd2, 1'b0};
        vecs[11] = '{4'h8, 4'h8, 32'h13121110, 1'b0, 4'h8, 8'h13, 2'd3, 1'b0};

        apply_reset();
        tick();
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_abort", 32'(lock_abort), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);

        for (int i = 0; i < NV; i++) begin
            tick();
            drive(vecs[i].valid, vecs[i].last, vecs[i].data);
            busy_hold = vecs[i].hold;
            #1;
            check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            if (vecs[i].exp_ready != 4'h0) begin
                tick();
                drive(4'h0, 4'h0, 32'h0);
                check($sformatf("v%0d_start", i), 32'(bus.tx_start), 32'd1);
                check($sformatf("v%0d_data", i), 32'(bus.tx_data), 32'(vecs[i].exp_data));
                check($sformatf("v%0d_grant", i), 32'(grant_id), 32'(vecs[i].exp_grant));
                check($sformatf("v%0d_locked", i), 32'(locked), 32'(vecs[i].exp_locked));
                wait_frame($sformatf("v%0d", i));
                check($sformatf("v%0d_data_hold", i), 32'(bus.tx_data), 32'(vecs[i].exp_data));
            end else begin
                repeat (3) begin
                    tick();
                    check($sformatf("v%0d_idle_ready", i), 32'(bus.req_ready), 32'd0);
                    check($sformatf("v%0d_idle_start", i), 32'(bus.tx_start), 32'd0);
                end
                check($sformatf("v%0d_grant", i), 32'(grant_id), 32'(vecs[i].exp_grant));
                check($sformatf("v%0d_locked", i), 32'(locked), 32'(vecs[i].exp_locked));
                drive(4'h0, 4'h0, 32'h0);
                busy_hold = 1'b0;
            end
        end

        // Single byte from req1 held valid: accept-to-accept spacing and post-busy latency.
        apply_reset();
        frame_len = 12;
        tick();
        drive(4'h2, 4'h2, 32'h0000A500);
        #1;
        check("sb_ready", 32'(bus.req_ready), 32'h2);
        t         = 0;
        fall_t    = -100;
        prev_busy = 1'b0;
        do begin
            tick();
            t++;
            if (t == 1) begin
                check("sb_start", 32'(bus.tx_start), 32'd1);
                check("sb_data", 32'(bus.tx_data), 32'hA5);
            end
            if (prev_busy && !bus.tx_busy) fall_t = t;
            prev_busy = bus.tx_busy;
        end while (bus.req_ready == 4'h0 && t < 200);
        check("sb_spacing", 32'(t), 32'(frame_len + 3 + EXTRA));
        check("sb_after_fall", 32'(t - fall_t), 32'(1 + EXTRA));
        tick();
        drive(4'h0, 4'h0, 32'h0);
        wait_frame("sb2");
        tick();
        drive(4'hF, 4'hF, 32'h13121110);
        #1;
        check("sb_rr_next", 32'(bus.req_ready), 32'h4);
        tick();
        drive(4'h0, 4'h0, 32'h0);
        wait_frame("sb3");

        // Lock timeout: req0 opens a packet then stalls while req3 waits.
        apply_reset();
        frame_len = 5;
        tick();
        drive(4'h1, 4'h0, 32'h00000040);
        #1;
        check("to_ready0", 32'(bus.req_ready), 32'h1);
        tick();
        drive(4'h8, 4'h8, 32'h77000000);
        check("to_locked", 32'(locked), 32'd1);
        wait_frame("to");
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("to_wait%0d", k), {27'd0, lock_abort, bus.req_ready},
                  {27'd0, 1'b0, 4'h0});
            check($sformatf("to_lock%0d", k), 32'(locked), 32'd1);
        end
        tick();
        check("to_abort", 32'(lock_abort), 32'd1);
        check("to_unlock", 32'(locked), 32'd0);
        check("to_ready3", 32'(bus.req_ready), 32'h8);
        tick();
        drive(4'h0, 4'h0, 32'h0);
        check("to_abort_off", 32'(lock_abort), 32'd0);
        check("to_start3", 32'(bus.tx_start), 32'd1);
        check("to_data3", 32'(bus.tx_data), 32'h77);
        check("to_grant3", 32'(grant_id), 32'd3);
        wait_frame("to3");

        // Busy held at IDLE, then reset asserted while waiting for busy to fall.
        apply_reset();
        frame_len = 20;
        tick();
        busy_hold = 1'b1;
        drive(4'h4, 4'h0, 32'h005C0000);
        #1;
        check("bh_ready", 32'(bus.req_ready), 32'h0);
        repeat (3) begin
            tick();
            check("bh_ready_hold", 32'(bus.req_ready), 32'h0);
        end
        tick();
        busy_hold = 1'b0;
        #1;
        check("bh_release", 32'(bus.req_ready), 32'h4);
        tick();
        drive(4'h0, 4'h0, 32'h0);
        check("bh_start", 32'(bus.tx_start), 32'd1);
        t = 0;
        while (!bus.tx_busy && t < 50) begin
            tick();
            t++;
        end
        tick();
        tick();
        check("bh_mid_busy", 32'(bus.tx_busy), 32'd1);
        check("bh_mid_locked", 32'(locked), 32'd1);
        check("bh_mid_grant", 32'(grant_id), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_tx_start", 32'(bus.tx_start), 32'd0);
        check("ar_locked", 32'(locked), 32'd0);
        check("ar_grant", 32'(grant_id), 32'd0);
        check("ar_tx_data", 32'(bus.tx_data), 32'h00);
        tick();
        rst_n = 1'b1;
        tick();
        drive(4'h6, 4'h6, 32'h00223300);
        #1;
        check("ar_recover", 32'(bus.req_ready), 32'h2);
        tick();
        drive(4'h0, 4'h0, 32'h0);
        check("ar_recover_data", 32'(bus.tx_data), 32'h33);
        wait_frame("ar");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
